adder_sweep_checker: RTL and testbench

Synthesizable on-FPGA stimulus-and-check stage for the prefix-adder family. It generates every operand pair in a configurable range and drives them into a prefix adder under test. It then samples the adder's sum after a fixed latency, compares it with a reference `A + B`, and reports error count, pass/fail and the first failing vector. It sits directly around the adder (upstream on A/B, downstream on S), so the exhaustive check can run in hardware rather than in simulation.

---
 rtl/adder_sweep_checker.sv | 143 ++++++++++++++
 tb/tb_adder_sweep_checker.sv | 235 +++++++++++++++++++++++
 2 files changed

// File: rtl/adder_sweep_checker.sv
// adder_sweep_checker: exhaustive operand sweep and result check
// for a prefix adder under test, with first-failure capture.
module adder_sweep_checker #(
    parameter int N     = 4,
    parameter int START = 0,
    parameter int STOP  = (1 << N) - 1,
    parameter int LAT   = 1,
    parameter int ERR_W = 16
) (
    input  logic             clk,
    input  logic             rst_n,
    input  logic             start,
    output logic [N-1:0]     a_out,
    output logic [N-1:0]     b_out,
    input  logic [N:0]       s_in,
    output logic             busy,
    output logic             done,
    output logic             pass,
    output logic [ERR_W-1:0] err_count,
    output logic             err_valid,
    output logic [N-1:0]     first_a,
    output logic [N-1:0]     first_b,
    output logic [N:0]       first_s
);

    typedef enum logic [1:0] {
        IDLE,
        RUN,
        DRAIN,
        DONE
    } state_t;

    typedef struct packed {
        logic         v;
        logic [N-1:0] a;
        logic [N-1:0] b;
    } tag_t;

    localparam logic [N-1:0] LO = N'(START);
    localparam logic [N-1:0] HI = N'(STOP);

    state_t       state;
    state_t       state_nx;
    tag_t         launch;
    tag_t         tail;
    logic [N:0]   ref_s;
    logic         mism;
    logic         last_cmp;
    logic         at_end;
    logic         go;

    assign at_end = (a_out == HI) && (b_out == HI);
    assign go     = start && ((state == IDLE) || (state == DONE));
    assign launch = '{v: (state == RUN), a: a_out, b: b_out};

    generate
        if (LAT == 1) begin : g_comb
            assign tail = launch;
        end else begin : g_pipe
            tag_t pipe [LAT-1];
            // Tag pipeline: each launched pair travels with its sum.
            always_ff @(posedge clk) begin
                if (!rst_n) begin
                    for (int k = 0; k < LAT - 1; k++) pipe[k] <= '0;
                end else begin
                    pipe[0] <= launch;
                    for (int k = 1; k < LAT - 1; k++) pipe[k] <= pipe[k-1];
                end
            end
            assign tail = pipe[LAT-2];
        end
    endgenerate

    assign ref_s    = {1'b0, tail.a} + {1'b0, tail.b};
    assign mism     = tail.v && (s_in != ref_s);
    assign last_cmp = tail.v && (tail.a == HI) && (tail.b == HI);

    assign busy = (state == RUN) || (state == DRAIN);
    assign done = (state == DONE);

    // State register.
    always_ff @(posedge clk) begin
        if (!rst_n) state <= IDLE;
        else        state <= state_nx;
    end

    // Next state: leave for DONE on the edge comparing the last pair.
    always_comb begin
        state_nx = state;
        unique case (state)
            IDLE, DONE: if (start) state_nx = RUN;
            RUN: begin
                if (last_cmp)    state_nx = DONE;
                else if (at_end) state_nx = DRAIN;
            end
            DRAIN: if (last_cmp) state_nx = DONE;
            default: state_nx = IDLE;
        endcase
    end

    // Operand sweep, error counting, first-failure capture and verdict.
    always_ff @(posedge clk) begin
        if (!rst_n) begin
            a_out     <= LO;
            b_out     <= LO;
            pass      <= 1'b0;
            err_count <= '0;
            err_valid <= 1'b0;
            first_a   <= '0;
            first_b   <= '0;
            first_s   <= '0;
        end else if (go) begin
            a_out     <= LO;
            b_out     <= LO;
            pass      <= 1'b0;
            err_count <= '0;
            err_valid <= 1'b0;
            first_a   <= '0;
            first_b   <= '0;
            first_s   <= '0;
        end else begin
            if (state == RUN && !at_end) begin
                if (b_out != HI) begin
                    b_out <= b_out + N'(1);
                end else begin
                    b_out <= LO;
                    a_out <= a_out + N'(1);
                end
            end
            if (mism) begin
                if (err_count != '1) err_count <= err_count + ERR_W'(1);
                if (!err_valid) begin
                    err_valid <= 1'b1;
                    first_a   <= tail.a;
                    first_b   <= tail.b;
                    first_s   <= s_in;
                end
            end
            if (busy && state_nx == DONE) pass <= !(err_valid || mism);
        end
    end

endmodule

// File: tb/tb_adder_sweep_checker.sv
// tb_adder_sweep_checker: directed checks of the sweep checker
// against correct, faulty and registered adder models.
module tb_adder_sweep_checker;

    logic clk = 1'b0;
    logic rst_n;
    logic start1, start2, start3;
    logic fault1, fault3, use_reg;

    int n_vec = 0;
    int n_err = 0;

    logic [3:0]  a1, b1, fa1, fb1;
    logic [4:0]  s1, sreg1, fs1;
    logic        busy1, done1, pass1, ev1;
    logic [15:0] err1;

    logic [3:0]  a2, b2, fa2, fb2;
    logic [4:0]  s2, fs2;
    logic        busy2, done2, pass2, ev2;
    logic [15:0] err2;

    logic [3:0]  a3, b3, fa3, fb3;
    logic [4:0]  s3, fs3;
    logic        busy3, done3, pass3, ev3;
    logic [3:0]  err3;

    always #5 clk = ~clk;

    function automatic logic [4:0] add(input logic [3:0] a,
                                       input logic [3:0] b,
                                       input logic f);
        logic [4:0] r;
        r = {1'b0, a} + {1'b0, b};
        if (f) r[0] = 1'b0;
        return r;
    endfunction

    always @(posedge clk) begin
        sreg1 <= add(a1, b1, fault1);
        s3    <= add(a3, b3, fault3);
    end

    assign s1 = use_reg ? sreg1 : add(a1, b1, fault1);
    assign s2 = add(a2, b2, 1'b0);

    adder_sweep_checker dut1 (
        .clk(clk), .rst_n(rst_n), .start(start1),
        .a_out(a1), .b_out(b1), .s_in(s1),
        .busy(busy1), .done(done1), .pass(pass1),
        .err_count(err1), .err_valid(ev1),
        .first_a(fa1), .first_b(fb1), .first_s(fs1)
    );

    adder_sweep_checker #(.START(3), .STOP(5)) dut2 (
        .clk(clk), .rst_n(rst_n), .start(start2),
        .a_out(a2), .b_out(b2), .s_in(s2),
        .busy(busy2), .done(done2), .pass(pass2),
        .err_count(err2), .err_valid(ev2),
        .first_a(fa2), .first_b(fb2), .first_s(fs2)
    );

    adder_sweep_checker #(.LAT(2), .ERR_W(4)) dut3 (
        .clk(clk), .rst_n(rst_n), .start(start3),
        .a_out(a3), .b_out(b3), .s_in(s3),
        .busy(busy3), .done(done3), .pass(pass3),
        .err_count(err3), .err_valid(ev3),
        .first_a(fa3), .first_b(fb3), .first_s(fs3)
    );

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic chk(input string tag,
                       input logic [31:0] obs,
                       input logic [31:0] exp);
        n_vec++;
        assert (obs === exp) else begin
            n_err++;
            $error("FAIL %s: observed %0d expected %0d", tag, obs, exp);
        end
    endtask

    initial begin
        rst_n = 1'b0;
        start1 = 1'b0; start2 = 1'b0; start3 = 1'b0;
        fault1 = 1'b0; fault3 = 1'b0; use_reg = 1'b0;
        repeat (3) tick();

        chk("rst_busy", 32'(busy1), 0);
        chk("rst_done", 32'(done1), 0);
        chk("rst_pass", 32'(pass1), 0);
        chk("rst_err", 32'(err1), 0);
        chk("rst_ev", 32'(ev1), 0);
        chk("rst_a", 32'(a1), 0);
        chk("rst_b", 32'(b1), 0);
        chk("rst_first", 32'({fa1, fb1, fs1}), 0);
        chk("rst_a2", 32'(a2), 3);
        chk("rst_b2", 32'(b2), 3);

        rst_n = 1'b1;
        tick();

        // Edge 0 of a clean sweep on all three instances.
        start1 = 1'b1; start2 = 1'b1; start3 = 1'b1;
        tick();
        start1 = 1'b0; start2 = 1'b0; start3 = 1'b0;
        chk("e0_busy", 32'(busy1), 1);
        chk("e0_done", 32'(done1), 0);
        chk("e0_a", 32'(a1), 0);
        chk("e0_b", 32'(b1), 0);
        chk("e0_a2", 32'(a2), 3);
        chk("e0_b2", 32'(b2), 3);

        for (int i = 1; i <= 257; i++) begin
            tick();
            if (i == 101) start1 = 1'b0;
            if (i <= 8) begin
                chk("seq_a2", 32'(a2), 32'(3 + i / 3));
                chk("seq_b2", 32'(b2), 32'(3 + i % 3));
            end
            if (i == 8) begin
                chk("e8_done2", 32'(done2), 0);
                chk("e8_busy2", 32'(busy2), 1);
            end
            if (i == 9) begin
                chk("e9_done2", 32'(done2), 1);
                chk("e9_busy2", 32'(busy2), 0);
                chk("e9_pass2", 32'(pass2), 1);
                chk("e9_err2", 32'(err2), 0);
            end
            if (i == 12) begin
                chk("hold_a2", 32'(a2), 5);
                chk("hold_b2", 32'(b2), 5);
            end
            if (i == 100) start1 = 1'b1;
            if (i == 101) begin
                chk("midstart_a", 32'(a1), 6);
                chk("midstart_b", 32'(b1), 5);
            end
            if (i == 255) begin
                chk("e255_done", 32'(done1), 0);
                chk("e255_busy", 32'(busy1), 1);
                chk("e255_pass", 32'(pass1), 0);
            end
            if (i == 256) begin
                chk("e256_done", 32'(done1), 1);
                chk("e256_busy", 32'(busy1), 0);
                chk("e256_pass", 32'(pass1), 1);
                chk("e256_err", 32'(err1), 0);
                chk("e256_ev", 32'(ev1), 0);
                chk("e256_a", 32'(a1), 15);
                chk("e256_b", 32'(b1), 15);
                chk("e256_done3", 32'(done3), 0);
                chk("e256_busy3", 32'(busy3), 1);
            end
            if (i == 257) begin
                chk("e257_done3", 32'(done3), 1);
                chk("e257_pass3", 32'(pass3), 1);
                chk("e257_err3", 32'(err3), 0);
            end
        end

        // Stuck-at-0 on S[0]: odd sums fail.
        fault1 = 1'b1; fault3 = 1'b1;
        start1 = 1'b1; start3 = 1'b1;
        tick();
        start1 = 1'b0; start3 = 1'b0;
        chk("restart_done", 32'(done1), 0);
        chk("restart_pass", 32'(pass1), 0);
        chk("restart_a", 32'(a1), 0);
        chk("restart_b", 32'(b1), 0);
        repeat (257) tick();
        chk("f_done", 32'(done1), 1);
        chk("f_err", 32'(err1), 128);
        chk("f_ev", 32'(ev1), 1);
        chk("f_fa", 32'(fa1), 0);
        chk("f_fb", 32'(fb1), 1);
        chk("f_fs", 32'(fs1), 0);
        chk("f_pass", 32'(pass1), 0);
        chk("f_done3", 32'(done3), 1);
        chk("f_err3_sat", 32'(err3), 15);
        chk("f_fa3", 32'(fa3), 0);
        chk("f_fb3", 32'(fb3), 1);
        chk("f_fs3", 32'(fs3), 0);
        chk("f_pass3", 32'(pass3), 0);

        // Registered adder checked with LAT=1 must report errors.
        fault1 = 1'b0; use_reg = 1'b1;
        start1 = 1'b1;
        tick();
        start1 = 1'b0;
        repeat (256) tick();
        chk("reg_done", 32'(done1), 1);
        chk("reg_errnz", 32'(err1 != 0), 1);
        chk("reg_pass", 32'(pass1), 0);

        // Reset in the middle of a failing sweep.
        use_reg = 1'b0; fault1 = 1'b1;
        start1 = 1'b1;
        tick();
        start1 = 1'b0;
        repeat (50) tick();
        chk("pre_rst_ev", 32'(ev1), 1);
        rst_n = 1'b0;
        tick();
        chk("mrst_busy", 32'(busy1), 0);
        chk("mrst_done", 32'(done1), 0);
        chk("mrst_pass", 32'(pass1), 0);
        chk("mrst_err", 32'(err1), 0);
        chk("mrst_ev", 32'(ev1), 0);
        chk("mrst_ab", 32'({a1, b1}), 0);
        chk("mrst_first", 32'({fa1, fb1, fs1}), 0);
        rst_n = 1'b1;
        fault1 = 1'b0;
        tick();

        // Fresh full sweep after reset.
        start1 = 1'b1;
        tick();
        start1 = 1'b0;
        repeat (255) tick();
        chk("fresh_e255", 32'(done1), 0);
        tick();
        chk("fresh_done", 32'(done1), 1);
        chk("fresh_pass", 32'(pass1), 1);
        chk("fresh_err", 32'(err1), 0);

        $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
        $finish;
    end

endmodule
